// File: rtl/apb_pkg.sv
// Shared types and default geometry for the APB initiator and its address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_init_state_e;

    localparam int APB_NUM_SLV = 8;
    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_SEL_LSB = 24;

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational completer decode: upper address field -> one-hot select, index, decode error.
module apb_slave_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int NUM_SLV = APB_NUM_SLV,
    parameter int SEL_LSB = APB_SEL_LSB,
    parameter int IDX_W   = (NUM_SLV < 2) ? 1 : $clog2(NUM_SLV)
) (
    input  logic [ADDR_W-1:SEL_LSB] addr_hi,
    output logic [NUM_SLV-1:0]      sel,
    output logic [IDX_W-1:0]        idx,
    output logic                    dec_err
);

    logic upper_nz;
    logic out_range;

    assign idx = addr_hi[SEL_LSB +: IDX_W];

    generate
        if (SEL_LSB + IDX_W < ADDR_W) begin : g_upper
            assign upper_nz = |addr_hi[ADDR_W-1:SEL_LSB+IDX_W];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end

        // Index values past the last completer only exist for non power-of-two counts.
        if (NUM_SLV < (1 << IDX_W)) begin : g_range
            assign out_range = (idx >= IDX_W'(NUM_SLV));
        end else begin : g_no_range
            assign out_range = 1'b0;
        end
    endgenerate

    assign dec_err = upper_nz | out_range;

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
            assign sel[gi] = !dec_err && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/apb_initiator.sv
// APB initiator: one request at a time through SETUP/ACCESS, one response strobe per request,
// with a wait-state timeout so a stuck completer cannot hang the requester.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int NUM_SLV     = APB_NUM_SLV,
    parameter int SEL_LSB     = APB_SEL_LSB,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_write,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PWRITE,
    output logic [NUM_SLV-1:0]        PSELx,
    output logic                      PENABLE,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int IDX_W = (NUM_SLV < 2) ? 1 : $clog2(NUM_SLV);
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    apb_init_state_e     state_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                rsp_err_reg;
    logic                rsp_timeout_reg;
    logic [ADDR_W-1:0]   paddr_reg;
    logic [DATA_W-1:0]   pwdata_reg;
    logic                pwrite_reg;
    logic [NUM_SLV-1:0]  psel_reg;
    logic                penable_reg;

    logic [NUM_SLV-1:0]  dec_sel;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_err;

    logic [DATA_W-1:0]   prdata_sel;
    logic                pready_sel;
    logic                pslverr_sel;

    apb_slave_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SEL_LSB (SEL_LSB),
        .IDX_W   (IDX_W)
    ) u_decode (
        .addr_hi (req_addr[ADDR_W-1:SEL_LSB]),
        .sel     (dec_sel),
        .idx     (dec_idx),
        .dec_err (dec_err)
    );

    // Only the latched completer's return signals are ever looked at.
    assign prdata_sel  = PRDATA[idx_reg*DATA_W +: DATA_W];
    assign pready_sel  = PREADY[idx_reg];
    assign pslverr_sel = PSLVERR[idx_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            idx_reg         <= '0;
            req_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            pwrite_reg      <= 1'b0;
            psel_reg        <= '0;
            penable_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!req_ready_reg) begin
                        req_ready_reg <= 1'b1;
                    end else if (req_valid) begin
                        req_ready_reg <= 1'b0;
                        idx_reg       <= dec_idx;
                        wait_cnt_reg  <= '0;
                        if (dec_err) begin
                            // No APB cycle; the bus keeps showing the previous transfer.
                            state_reg       <= RESP;
                            rsp_valid_reg   <= 1'b1;
                            rsp_err_reg     <= 1'b1;
                            rsp_timeout_reg <= 1'b0;
                            rsp_rdata_reg   <= '0;
                        end else begin
                            state_reg  <= SETUP;
                            paddr_reg  <= req_addr;
                            pwdata_reg <= req_wdata;
                            pwrite_reg <= req_write;
                            psel_reg   <= dec_sel;
                        end
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_sel) begin
                        state_reg     <= RESP;
                        psel_reg      <= '0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= pslverr_sel;
                        rsp_rdata_reg <= (!pwrite_reg && !pslverr_sel) ? prdata_sel : '0;
                    end else if (TIMEOUT_EN && wait_cnt_reg == TO_LAST) begin
                        state_reg       <= RESP;
                        psel_reg        <= '0;
                        penable_reg     <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_err_reg     <= 1'b1;
                        rsp_timeout_reg <= 1'b1;
                        rsp_rdata_reg   <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_reg       <= IDLE;
                    req_ready_reg   <= 1'b1;
                    rsp_valid_reg   <= 1'b0;
                    rsp_err_reg     <= 1'b0;
                    rsp_timeout_reg <= 1'b0;
                    rsp_rdata_reg   <= '0;
                    wait_cnt_reg    <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign PADDR       = paddr_reg;
    assign PWDATA      = pwdata_reg;
    assign PWRITE      = pwrite_reg;
    assign PSELx       = psel_reg;
    assign PENABLE     = penable_reg;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: zero-wait write, waited read, slave error, decode error,
// timeout and mid-transfer reset, with hand-computed expectations checked cycle by cycle.
module tb_apb_initiator;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      req_valid;
    logic                      req_ready;
    logic [ADDR_W-1:0]         req_addr;
    logic                      req_write;
    logic [DATA_W-1:0]         req_wdata;
    logic                      rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PWRITE;
    logic [NUM_SLV-1:0]        PSELx;
    logic                      PENABLE;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int bus_viol  = 0;

    always #5 clk = ~clk;

    apb_initiator #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_SLV     (NUM_SLV),
        .SEL_LSB     (24),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    // Bus invariant: PSELx zero or one-hot, PENABLE only with a select.
    always @(negedge clk) begin
        if (!rst) begin
            if (((PSELx & (PSELx - 8'd1)) != 8'd0) || (PENABLE && PSELx == 8'd0))
                bus_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        req_addr  = addr;
        req_write = wr;
        req_wdata = wdata;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = '0;
        PSLVERR   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_psel", PSELx, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", PADDR, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_req_ready", req_ready, 1);

        // 1: zero-wait write to slave 2
        PREADY = 8'h04;
        issue(32'h0200_0010, 1'b1, 32'hDEAD_BEEF);
        chk("w_setup_psel", PSELx, 8'h04);
        chk("w_setup_penable", PENABLE, 0);
        chk("w_setup_paddr", PADDR, 32'h0200_0010);
        chk("w_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
        chk("w_setup_pwrite", PWRITE, 1);
        chk("w_setup_req_ready", req_ready, 0);
        tick();
        chk("w_access_psel", PSELx, 8'h04);
        chk("w_access_penable", PENABLE, 1);
        chk("w_access_rsp_valid", rsp_valid, 0);
        tick();
        chk("w_rsp_valid", rsp_valid, 1);
        chk("w_rsp_err", rsp_err, 0);
        chk("w_rsp_rdata", rsp_rdata, 0);
        chk("w_rsp_psel", PSELx, 0);
        $display("txn write addr=%h data=%h err=%0b", 32'h0200_0010, 32'hDEAD_BEEF, rsp_err);
        tick();
        chk("w_idle_rsp_valid", rsp_valid, 0);
        chk("w_idle_req_ready", req_ready, 1);

        // 2: read slave 5 with three wait states; other slaves flag errors that must be ignored
        PREADY  = 8'h00;
        PSLVERR = 8'hDF;
        PRDATA[5*DATA_W +: DATA_W] = 32'h1234_5678;
        issue(32'h0500_0004, 1'b0, 32'h0);
        chk("r_setup_psel", PSELx, 8'h20);
        chk("r_setup_pwrite", PWRITE, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_wait_psel", PSELx, 8'h20);
            chk("r_wait_paddr", PADDR, 32'h0500_0004);
            chk("r_wait_penable", PENABLE, 1);
            chk("r_wait_rsp_valid", rsp_valid, 0);
        end
        tick();
        PREADY = 8'h20;
        chk("r_ready_cycle_rsp_valid", rsp_valid, 0);
        tick();
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("r_rsp_err", rsp_err, 0);
        $display("txn read addr=%h rdata=%h err=%0b", 32'h0500_0004, rsp_rdata, rsp_err);
        tick();
        PREADY  = 8'h00;
        PSLVERR = 8'h00;
        chk("r_idle_req_ready", req_ready, 1);

        // 3: read slave 7 returning PSLVERR while other slaves toggle
        PREADY  = 8'h7F;
        PSLVERR = 8'h7F;
        PRDATA[7*DATA_W +: DATA_W] = 32'hCAFE_F00D;
        issue(32'h0700_0000, 1'b0, 32'h0);
        chk("e_setup_psel", PSELx, 8'h80);
        tick();
        chk("e_access1_rsp_valid", rsp_valid, 0);
        chk("e_access1_penable", PENABLE, 1);
        PREADY  = 8'h00;
        PSLVERR = 8'h00;
        tick();
        chk("e_access2_rsp_valid", rsp_valid, 0);
        PREADY  = 8'hD5;
        PSLVERR = 8'h80;
        tick();
        chk("e_rsp_valid", rsp_valid, 1);
        chk("e_rsp_err", rsp_err, 1);
        chk("e_rsp_rdata", rsp_rdata, 0);
        chk("e_rsp_timeout", rsp_timeout, 0);
        $display("txn read addr=%h rdata=%h err=%0b", 32'h0700_0000, rsp_rdata, rsp_err);
        tick();
        PREADY  = 8'h00;
        PSLVERR = 8'h00;

        // 4: decode error, no bus activity, response one cycle after acceptance
        issue(32'h0800_0000, 1'b1, 32'h5555_AAAA);
        chk("d_rsp_valid", rsp_valid, 1);
        chk("d_rsp_err", rsp_err, 1);
        chk("d_rsp_timeout", rsp_timeout, 0);
        chk("d_psel", PSELx, 0);
        chk("d_paddr_held", PADDR, 32'h0700_0000);
        $display("txn write addr=%h decode_err=%0b", 32'h0800_0000, rsp_err);
        tick();
        chk("d_idle_rsp_valid", rsp_valid, 0);
        chk("d_idle_req_ready", req_ready, 1);

        // 5: slave 1 never ready -> timeout after 16 ACCESS cycles
        PREADY = 8'hFD;
        issue(32'h0100_0008, 1'b0, 32'h0);
        chk("t_setup_psel", PSELx, 8'h02);
        begin
            int early = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (rsp_valid || !PENABLE || PSELx != 8'h02) early++;
            end
            chk("t_wait_16_cycles", early, 0);
        end
        tick();
        chk("t_rsp_valid", rsp_valid, 1);
        chk("t_rsp_err", rsp_err, 1);
        chk("t_rsp_timeout", rsp_timeout, 1);
        chk("t_rsp_rdata", rsp_rdata, 0);
        chk("t_psel", PSELx, 0);
        $display("txn read addr=%h timeout=%0b", 32'h0100_0008, rsp_timeout);
        tick();
        chk("t_idle_req_ready", req_ready, 1);
        PREADY = 8'h08;
        issue(32'h0300_0000, 1'b1, 32'h0BAD_F00D);
        chk("t_next_psel", PSELx, 8'h08);
        tick();
        tick();
        chk("t_next_rsp_valid", rsp_valid, 1);
        chk("t_next_rsp_err", rsp_err, 0);
        chk("t_next_rsp_timeout", rsp_timeout, 0);
        $display("txn write addr=%h data=%h err=%0b", 32'h0300_0000, 32'h0BAD_F00D, rsp_err);
        tick();
        PREADY = 8'h00;

        // 6: reset asserted during ACCESS aborts without a response
        issue(32'h0400_0000, 1'b0, 32'h0);
        tick();
        chk("x_access_penable", PENABLE, 1);
        rst = 1'b1;
        tick();
        chk("x_rst_psel", PSELx, 0);
        chk("x_rst_penable", PENABLE, 0);
        chk("x_rst_rsp_valid", rsp_valid, 0);
        chk("x_rst_req_ready", req_ready, 0);
        rst = 1'b0;
        tick();
        chk("x_post_rsp_valid", rsp_valid, 0);
        chk("x_post_req_ready", req_ready, 1);
        tick();
        chk("x_post2_rsp_valid", rsp_valid, 0);
        $display("txn read addr=%h aborted by reset", 32'h0400_0000);

        chk("bus_invariant_violations", bus_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

APB initiator (requester) that converts single-beat requests from the bridge core into APB SETUP/ACCESS transfers across eight completers. It drives PADDR, PWDATA, PWRITE, one-hot PSELx and PENABLE. It samples PRDATA, PREADY and PSLVERR from the selected completer and returns one response per request. A wait-state timeout guarantees a hung completer cannot stall the bridge.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SLV, 8, completer count; fixes PSELx width and the 3-bit slave index
- SEL_LSB, 24, LSB of the slave-index field; index = addr[SEL_LSB+2:SEL_LSB]
- TIMEOUT_CYC, 16, maximum ACCESS cycles with PREADY low; 0 disables the timeout

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_W  byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response strobe; no backpressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  PSLVERR, decode error, or timeout
- rsp_timeout  out  1  error was caused by timeout
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PWRITE  out  1  APB direction
- PSELx  out  NUM_SLV  one-hot completer select
- PENABLE  out  1  ACCESS phase
- PRDATA  in  NUM_SLV×DATA_W  per-completer read data, slave i at [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLV  per-completer ready
- PSLVERR  in  NUM_SLV  per-completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - req_ready = 1.
  - On acceptance, latch addr, write, wdata and slave index.
  - If addr bits above SEL_LSB+2 are nonzero, this is a decode error: go to RESP with rsp_err = 1 and issue no APB transfer.
  - Otherwise go to SETUP.
- SETUP: PSELx[idx] = 1, PENABLE = 0, PADDR/PWDATA/PWRITE driven from the latch. Next state is always ACCESS.
- ACCESS
  - PENABLE = 1; PSELx, PADDR, PWDATA and PWRITE are held stable.
  - The wait counter increments each cycle PREADY[idx] = 0.
  - On PREADY[idx] = 1: capture PRDATA[idx] (reads only) and PSLVERR[idx], then go to RESP.
  - If the counter reaches TIMEOUT_CYC with PREADY still low: go to RESP with rsp_err = rsp_timeout = 1 and rsp_rdata = 0.
- RESP
  - rsp_valid = 1 for exactly one cycle; PSELx = 0, PENABLE = 0. Next state is IDLE.
  - rsp_err = PSLVERR[idx] on a normal completion. A write with PSLVERR still reports rsp_err.
- PREADY and PSLVERR of non-selected completers are ignored.
- PADDR, PWDATA and PWRITE hold their last value outside transfers.
- Requests are never queued. req_valid with req_ready = 0 is simply not accepted.

## Timing
- Reset: all outputs 0, state IDLE, wait counter 0. The next cycle has req_ready = 1.
- Reset mid-transfer: PSELx, PENABLE and rsp_valid are 0 at the edge after rst is sampled. No response is issued for the aborted request.
- Zero-wait transfer accepted at edge N:
  - SETUP during cycle N+1, ACCESS during N+2, rsp_valid during N+3.
  - req_ready returns during N+4, so the throughput is 1 transfer per 4 cycles.
- Each wait state adds one cycle between ACCESS and RESP.
- A timeout asserts rsp_valid in the cycle after the TIMEOUT_CYC-th low-PREADY ACCESS cycle.
- A decode error accepted at N gives rsp_valid during N+1.
- PSELx is 0 or exactly one-hot at all times. PENABLE = 1 only when PSELx ≠ 0.

## Structure
- apb_pkg holds:
  - the state enum `apb_init_state_e` (IDLE, SETUP, ACCESS, RESP)
  - NUM_SLV, ADDR_W and DATA_W defaults
  - the SEL_LSB default
- Sub-module apb_slave_decode (combinational) takes the address and returns the one-hot select, the index and the decode-error flag. It is shared with the monitor's reference model.
- Per-slave PRDATA/PREADY/PSLVERR muxing is inline in apb_initiator.

## Test plan
- Write 0x0200_0010 / 0xDEAD_BEEF, PREADY[2] = 1 immediately:
  - PSELx = 0x04 with PENABLE = 0 for one cycle, then PENABLE = 1.
  - rsp_valid 3 cycles after acceptance, rsp_err = 0.
- Read 0x0500_0004, PREADY[5] held low 3 cycles, PRDATA[5] = 0x1234_5678:
  - PADDR and PSELx are stable through all wait states.
  - rsp_rdata = 0x1234_5678 at acceptance + 6.
- Read to slave 7 with PSLVERR[7] = 1 on the ready cycle, while PREADY and PSLVERR of the other slaves toggle:
  - rsp_err = 1 and rsp_rdata = 0.
  - Non-selected inputs have no effect.
- Address 0x0800_0000 (decode error): PSELx stays 0, rsp_valid = 1 with rsp_err = 1 at acceptance + 1.
- PREADY[1] stuck low with TIMEOUT_CYC = 16:
  - rsp_err = rsp_timeout = 1 after 16 ACCESS cycles, then PSELx = 0.
  - The next request is accepted normally.
- rst asserted during ACCESS:
  - All outputs are 0 next cycle and no rsp_valid is issued.
  - req_ready = 1 after rst deasserts.
